// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if
//   Bundles the mode/button inputs and the scan/edit outputs of the
//   seven-segment scan controller.
//   master : mode/button logic side (drives mode, alarm_mode, btn_next,
//            btn_exit; observes the scan outputs)
//   slave  : the scan controller itself
//   Signals:
//     mode[5:0]       current clock mode (3 = alarm)
//     alarm_mode      alarm value being set/displayed
//     btn_next        1-cycle pulse: enter edit / advance field
//     btn_exit        1-cycle pulse: leave edit
//     light[2:0]      digit index for the value selector
//     an[7:0]         active-low digit enables
//     edit_field[1:0] 0 none, 1 hour, 2 minute, 3 second
//     blank           segments dark for the current digit
//     frame_tick      1-cycle pulse when light wraps 7 -> 0
interface disp_scan_ctrl_if;
  logic [5:0] mode;
  logic       alarm_mode;
  logic       btn_next;
  logic       btn_exit;
  logic [2:0] light;
  logic [7:0] an;
  logic [1:0] edit_field;
  logic       blank;
  logic       frame_tick;

  modport master (
    output mode, alarm_mode, btn_next, btn_exit,
    input  light, an, edit_field, blank, frame_tick
  );

  modport slave (
    input  mode, alarm_mode, btn_next, btn_exit,
    output light, an, edit_field, blank, frame_tick
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Scan and edit-cursor controller for an 8-digit seven-segment display.
//   Steps the digit index every SCAN_DIV cycles, drives the matching
//   active-low digit enable, tracks the alarm field under edit and
//   produces a blank strobe (digits 6/7 always dark; edited pair flashes).
//   Optional feature macro: EDIT_BLINK_EN (when undefined, no blinking;
//   blank covers digits 6/7 only).
//   Ports:
//     clk  rising-edge system clock
//     rst  synchronous, active-high reset
//     bus  disp_scan_ctrl_if.slave (mode/buttons in, scan/edit outputs)
//   Parameters:
//     SCAN_DIV  clock cycles per lit digit (>= 2)
//     BLINK_DIV full scan frames per blink half-period (>= 1)
module disp_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLINK_DIV = 64
) (
  input  logic             clk,
  input  logic             rst,
  disp_scan_ctrl_if.slave  bus
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  if (SCAN_DIV < 2) begin : g_bad_scan_div
    $error("SCAN_DIV must be at least 2");
  end
  if (BLINK_DIV < 1) begin : g_bad_blink_div
    $error("BLINK_DIV must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    EDIT_S = 2'd3
  } state_t;

  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       light;
  logic [2:0]       light_nxt;
  logic [7:0]       an;
  logic             frame_tick;
  logic             step;
  logic             wrap;

  state_t           state;
  state_t           state_nxt;
  logic             enter;
  logic             in_alarm;
  logic [1:0]       field;
  logic             blink_on;
  logic             blank;

  assign step      = (div_cnt == DIV_LAST);
  assign wrap      = step && (light == 3'd7);
  assign light_nxt = light + 3'd1;
  assign in_alarm  = (bus.mode == 6'd3) && bus.alarm_mode;
  assign field     = state;

  // Prescaler and digit scan
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      light      <= 3'd0;
      an         <= 8'hFE;
      frame_tick <= 1'b0;
    end else begin
      div_cnt    <= step ? '0 : div_cnt + DIV_W'(1);
      frame_tick <= wrap;
      if (step) begin
        light <= light_nxt;
        an    <= ~(8'b1 << light_nxt);
      end
    end
  end

  // Edit FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Edit FSM next state; leaving alarm mode or btn_exit overrides btn_next
  always_comb begin
    state_nxt = state;
    enter     = 1'b0;
    if (!in_alarm || bus.btn_exit) begin
      state_nxt = IDLE;
    end else if (bus.btn_next) begin
      case (state)
        IDLE:    state_nxt = EDIT_H;
        EDIT_H:  state_nxt = EDIT_M;
        EDIT_M:  state_nxt = EDIT_S;
        default: state_nxt = IDLE;
      endcase
    end
    enter = (state_nxt != IDLE) && (state_nxt != state);
  end

`ifdef EDIT_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt;
  logic             blink_phase;

  // Blink counter; a fresh field entry restarts the lit half-period,
  // taking priority over a coincident frame wrap
  always_ff @(posedge clk) begin
    if (rst || enter) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (wrap) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  assign blink_on = blink_phase;
`else
  assign blink_on = 1'b0;
`endif

  // Digits 6/7 are unused and always dark; the edited pair (field-1)
  // occupies digits {2*(field-1), 2*(field-1)+1}, i.e. light[2:1] == field-1.
  always_comb begin
    blank = 1'b0;
    if (light[2:1] == 2'b11) begin
      blank = 1'b1;
    end else if (blink_on && (state != IDLE) && (light[2:1] == (field - 2'd1))) begin
      blank = 1'b1;
    end
  end

  assign bus.light      = light;
  assign bus.an         = an;
  assign bus.edit_field = field;
  assign bus.blank      = blank;
  assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl
//   Self-checking bench for disp_scan_ctrl with SCAN_DIV=4, BLINK_DIV=2.
//   A cycle-count reference model derives every expected output from the
//   elapsed time since reset and the time the current field was entered.
module tb_disp_scan_ctrl;
  localparam int S     = 4;
  localparam int B     = 2;
  localparam int FRAME = 8 * S;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  disp_scan_ctrl_if bus();

  disp_scan_ctrl #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: cycles since reset, field (0..3), entry cycle
  int m_t     = 0;
  int m_state = 0;
  int m_entry = 0;

  function automatic logic [2:0] exp_light();
    return 3'((m_t / S) % 8);
  endfunction

  function automatic logic exp_blank();
    int l;
    l = (m_t / S) % 8;
    if (l >= 6) return 1'b1;
`ifdef EDIT_BLINK_EN
    if (m_state != 0) begin
      int n;
      n = m_t / FRAME - m_entry / FRAME;
      if (((n / B) % 2) == 1 && (l / 2) == (m_state - 1)) return 1'b1;
    end
`endif
    return 1'b0;
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [2:0] l;
    l = exp_light();
    return {l, 8'hFF ^ (8'd1 << l), 2'(m_state), exp_blank(),
            (m_t > 0 && (m_t % FRAME) == 0)};
  endfunction

  function automatic logic [14:0] obs_vec();
    return {bus.light, bus.an, bus.edit_field, bus.blank, bus.frame_tick};
  endfunction

  // Advance one clock: capture inputs, update the model, settle past the edge
  task automatic step_cycle();
    logic r, nx, ex, ok;
    int ns;
    r  = rst;
    nx = bus.btn_next;
    ex = bus.btn_exit;
    ok = (bus.mode == 6'd3) && bus.alarm_mode;
    @(posedge clk);
    if (r) begin
      m_t     = 0;
      m_state = 0;
    end else begin
      m_t++;
      ns = m_state;
      if (!ok || ex) ns = 0;
      else if (nx)   ns = (m_state + 1) % 4;
      if (ns != 0 && ns != m_state) m_entry = m_t;
      m_state = ns;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.mode = 6'd0; bus.alarm_mode = 1'b0;
    bus.btn_next = 1'b0; bus.btn_exit = 1'b0;
    step_cycle();
    step_cycle();
    rst = 1'b0;
    checks++;
    if (obs_vec() !== {3'd0, 8'hFE, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs_vec(), {3'd0, 8'hFE, 2'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_scan();
    int ft_cnt, ft_at;
    logic [5:0] md;
    ft_cnt = 0; ft_at = -1;
    for (int i = 0; i < 40; i++) begin
      md = 6'($urandom_range(0, 63));
      if (md == 6'd3) md = 6'd4;
      bus.mode = md;
      bus.alarm_mode = 1'($urandom % 2);
      bus.btn_next = ($urandom % 5 == 0);
      bus.btn_exit = ($urandom % 7 == 0);
      step_cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL scan t=%0d got=%h want=%h", m_t, obs_vec(), exp_vec());
      end
      if (bus.frame_tick) begin ft_cnt++; ft_at = m_t; end
    end
    bus.btn_next = 1'b0; bus.btn_exit = 1'b0;
    checks++;
    if (ft_cnt !== 1 || ft_at !== 32) begin
      errors++;
      $display("FAIL frame_tick count=%0d at=%0d want count=1 at=32", ft_cnt, ft_at);
    end
  endtask

  task automatic test_edit_seq();
    logic [1:0] want;
    bus.mode = 6'd3; bus.alarm_mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      want = 2'((k + 1) % 4);
      bus.btn_next = 1'b1;
      step_cycle();
      bus.btn_next = 1'b0;
      checks++;
      if (bus.edit_field !== want) begin
        errors++;
        $display("FAIL edit_seq field got=%0d want=%0d", bus.edit_field, want);
      end
      for (int j = 0; j < 9; j++) begin
        step_cycle();
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++;
          $display("FAIL edit_seq t=%0d got=%h want=%h", m_t, obs_vec(), exp_vec());
        end
      end
    end
  endtask

  task automatic test_blink_m();
    logic want;
    int l;
    rst = 1'b1; step_cycle(); rst = 1'b0;
    bus.mode = 6'd3; bus.alarm_mode = 1'b1;
    for (int i = 0; i < 200 && m_t < 9; i++) step_cycle();
    bus.btn_next = 1'b1; step_cycle(); bus.btn_next = 1'b0;
    for (int i = 0; i < 200 && m_t < 2 * FRAME - 1; i++) step_cycle();
    bus.btn_next = 1'b1; step_cycle(); bus.btn_next = 1'b0;
    checks++;
    if (bus.edit_field !== 2'd2 || m_t != 2 * FRAME) begin
      errors++;
      $display("FAIL blink_entry field=%0d t=%0d want field=2 t=%0d", bus.edit_field, m_t, 2 * FRAME);
    end
    for (int k = 0; k < 128; k++) begin
      if (k > 0) step_cycle();
      l = int'(bus.light);
      if (l >= 6) want = 1'b1;
`ifdef EDIT_BLINK_EN
      else if (l == 2 || l == 3) want = (k >= 64);
`endif
      else want = 1'b0;
      checks++;
      if (bus.blank !== want) begin
        errors++;
        $display("FAIL blink_m k=%0d light=%0d blank got=%b want=%b", k, l, bus.blank, want);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL blink_m_vec t=%0d got=%h want=%h", m_t, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_exit_priority();
    bus.mode = 6'd3; bus.alarm_mode = 1'b1;
    bus.btn_exit = 1'b1; step_cycle(); bus.btn_exit = 1'b0;
    bus.btn_next = 1'b1; step_cycle(); bus.btn_next = 1'b0;
    step_cycle(); step_cycle();
    checks++;
    if (bus.edit_field !== 2'd1) begin
      errors++;
      $display("FAIL exit_setup field got=%0d want=1", bus.edit_field);
    end
    bus.btn_next = 1'b1; bus.btn_exit = 1'b1;
    step_cycle();
    checks++;
    if (bus.edit_field !== 2'd0) begin
      errors++;
      $display("FAIL exit_priority field got=%0d want=0", bus.edit_field);
    end
    step_cycle();
    bus.btn_next = 1'b0; bus.btn_exit = 1'b0;
    checks++;
    if (bus.edit_field !== 2'd0) begin
      errors++;
      $display("FAIL exit_in_idle field got=%0d want=0", bus.edit_field);
    end
  endtask

  task automatic test_mode_leave();
    bus.mode = 6'd3; bus.alarm_mode = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.btn_next = 1'b1; step_cycle(); bus.btn_next = 1'b0;
      step_cycle();
    end
    checks++;
    if (bus.edit_field !== 2'd3) begin
      errors++;
      $display("FAIL mode_setup field got=%0d want=3", bus.edit_field);
    end
    bus.mode = 6'd1; step_cycle();
    checks++;
    if (bus.edit_field !== 2'd0) begin
      errors++;
      $display("FAIL mode_leave field got=%0d want=0", bus.edit_field);
    end
    bus.btn_next = 1'b1; step_cycle(); bus.btn_next = 1'b0;
    checks++;
    if (bus.edit_field !== 2'd0) begin
      errors++;
      $display("FAIL next_wrong_mode field got=%0d want=0", bus.edit_field);
    end
    bus.mode = 6'd3;
    bus.btn_next = 1'b1; step_cycle(); bus.btn_next = 1'b0;
    bus.alarm_mode = 1'b0; step_cycle();
    checks++;
    if (bus.edit_field !== 2'd0) begin
      errors++;
      $display("FAIL alarm_leave field got=%0d want=0", bus.edit_field);
    end
  endtask

  task automatic test_reset_mid();
    bus.mode = 6'd3; bus.alarm_mode = 1'b1;
    bus.btn_exit = 1'b1; step_cycle(); bus.btn_exit = 1'b0;
    bus.btn_next = 1'b1; step_cycle(); step_cycle(); bus.btn_next = 1'b0;
    for (int i = 0; i < 4 * FRAME && exp_light() != 3'd5; i++) step_cycle();
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) step_cycle();
    checks++;
    if (bus.light !== 3'd5 || bus.edit_field !== 2'd2) begin
      errors++;
      $display("FAIL reset_mid_setup light=%0d field=%0d want light=5 field=2", bus.light, bus.edit_field);
    end
    rst = 1'b1; step_cycle(); rst = 1'b0;
    checks++;
    if (obs_vec() !== {3'd0, 8'hFE, 2'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got=%h want=%h", obs_vec(), {3'd0, 8'hFE, 2'd0, 1'b0, 1'b0});
    end
    step_cycle(); step_cycle(); step_cycle();
    checks++;
    if (bus.light !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_div light after 3 got=%0d want=0", bus.light);
    end
    step_cycle();
    checks++;
    if (bus.light !== 3'd1 || bus.an !== 8'hFD) begin
      errors++;
      $display("FAIL reset_mid_div light after 4 got=%0d an=%h want=1 an=fd", bus.light, bus.an);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.mode       = ($urandom % 6 == 0) ? 6'($urandom_range(0, 63)) : 6'd3;
      bus.alarm_mode = ($urandom % 10 != 0);
      bus.btn_next   = ($urandom % 40 == 0);
      bus.btn_exit   = ($urandom % 60 == 0);
      rst            = ($urandom % 300 == 0);
      step_cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random t=%0d st=%0d got=%h want=%h", m_t, m_state, obs_vec(), exp_vec());
      end
    end
    rst = 1'b0; bus.btn_next = 1'b0; bus.btn_exit = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.mode = 6'd0; bus.alarm_mode = 1'b0;
    bus.btn_next = 1'b0; bus.btn_exit = 1'b0;
    test_reset();
    test_scan();
    test_edit_seq();
    test_blink_m();
    test_exit_priority();
    test_mode_leave();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Scan and edit-cursor controller for the 8-digit seven-segment display. It steps the digit index that drives the digit-value selector, generates the matching active-low digit enables, and tracks which time field (hour/minute/second) is being edited while the alarm is set. It also produces a blink-blank strobe so the field under edit flashes. It sits between the mode/button logic and the digit-value selector and segment decoder.

## Interface
Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays lit; must be ≥2.
- BLINK_DIV, 64: full scan frames per blink half-period; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous and active-high.
- mode  in  6  current clock mode; 3 = alarm.
- alarm_mode  in  1  1 = alarm value is being set or displayed.
- btn_next  in  1  single-cycle pulse: enter edit, or advance to the next field.
- btn_exit  in  1  single-cycle pulse: leave edit.
- light  out  3  digit index presented to the value selector.
- an  out  8  digit enables, active-low, one-hot-zero.
- edit_field  out  2  0 = none, 1 = hour, 2 = minute, 3 = second.
- blank  out  1  1 = segments must be dark for the current digit.
- frame_tick  out  1  one-cycle pulse when light wraps from 7 to 0.

## Operation
- Prescaler: div_cnt counts 0..SCAN_DIV-1, then wraps. step = (div_cnt == SCAN_DIV-1).
- Scan: on step, light becomes light+1 modulo 8. an = ~(8'b1 << light), registered together with light.
- frame_tick is registered and asserted in the cycle where light changes from 7 to 0.
- Blink: blink_cnt counts frame_ticks 0..BLINK_DIV-1. On its wrap, blink_phase toggles.
- Edit FSM has states IDLE, EDIT_H, EDIT_M, EDIT_S. edit_field encodes these as 0/1/2/3.
  - IDLE to EDIT_H: btn_next while mode==3 and alarm_mode==1.
  - EDIT_H to EDIT_M, EDIT_M to EDIT_S, and EDIT_S to IDLE: each on btn_next.
  - Any EDIT state to IDLE: on btn_exit, or whenever mode!=3 or alarm_mode==0.
  - btn_exit together with btn_next: exit wins, next state is IDLE.
  - Leaving the mode together with btn_next: next state is IDLE.
- Entering any EDIT state clears blink_cnt and blink_phase to 0. The edited field is therefore lit for a full half-period first.
- blank is combinational from registered state. It is 1 when:
  - light is 6 or 7, in any state; or
  - blinking is enabled, blink_phase==1, and light is in the edited pair (EDIT_H: 0,1; EDIT_M: 2,3; EDIT_S: 4,5).

## Timing
- Reset values: div_cnt=0, light=0, an=8'hFE, frame_tick=0, blink_cnt=0, blink_phase=0, state=IDLE, edit_field=0, blank=0.
- light advances exactly once every SCAN_DIV cycles. A full frame is 8·SCAN_DIV cycles; a blink half-period is 8·SCAN_DIV·BLINK_DIV cycles.
- Button response: edit_field updates in the cycle after the pulse (1-cycle latency). blank follows in that same cycle.
- Button pulses do not disturb div_cnt or light.
- Reset asserted mid-scan or mid-edit: all registers return to reset values on the next edge, and an=8'hFE in the following cycle.

## Configuration
- EDIT_BLINK_EN defined: blink_cnt and blink_phase are implemented; the edited pair blanks on blink_phase==1 as described.
- EDIT_BLINK_EN undefined: blink logic is removed and blank = (light==6 || light==7) only. The edit FSM and edit_field are unchanged.

## Test plan
Benches use SCAN_DIV=4 and BLINK_DIV=2.
- Reset, then run 40 cycles -> light steps 0,1,…,7,0,1 every 4 cycles; an tracks it (8'hFE, 8'hFD, …, 8'h7F); frame_tick high for exactly 1 cycle at cycle 32.
- mode=3, alarm_mode=1, btn_next ×3 spaced 10 cycles apart -> edit_field goes 1, 2, 3, each 1 cycle after its pulse; a 4th btn_next -> 0.
- With EDIT_BLINK_EN, in EDIT_M: blank=0 on light 2/3 for the first 64 cycles after entry, then 1 on light 2/3 for the next 64; blank=1 on light 6/7 throughout; blank=0 on light 0, 1, 4, 5 throughout.
- In EDIT_H, drive btn_next and btn_exit in the same cycle -> edit_field=0 next cycle.
- In EDIT_S, change mode from 3 to 1 -> edit_field=0 next cycle; btn_next with mode=1 -> stays 0.
- Assert rst for 1 cycle while light=5 and in EDIT_M -> next cycle light=0, an=8'hFE, edit_field=0, blank=0, and div_cnt restarts from 0.
